// File: rtl/ram_probe_clear.sv
// ============================================================================
// Module      : ram_probe_clear
// Description : Memory-size probe and zero-fill sequencer in front of a
//               single-word SDRAM command port. Writes signatures to
//               power-of-two probe addresses plus an aliasing guard word,
//               reads them back into a presence mask, then optionally sweeps
//               zeros across [0, CLEAR_LAST].
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_probe_clear #(
   parameter int              AW         = 27,
   parameter int              DW         = 16,
   parameter int              NPROBE     = 3,
   parameter int              BASE_BIT   = 24,
   parameter logic [DW-1:0]   SIG_SEED   = 16'h0C38,
   parameter logic [AW-1:0]   CLEAR_LAST = {AW{1'b1}}
) (
   input  logic              clk_sys,
   input  logic              RESET,
   input  logic              restart,
   input  logic              clear_en,
   input  logic              mem_ready,
   input  logic [DW-1:0]     mem_dout,
   output logic [AW-1:0]     mem_addr,
   output logic [DW-1:0]     mem_din,
   output logic              mem_we,
   output logic              mem_rd,
   output logic [NPROBE-1:0] size_mask,
   output logic              probe_done,
   output logic              clear_busy,
   output logic              clear_done,
   output logic [AW-1:0]     clr_addr
);

   // Command list: NPROBE signature writes, one guard write, NPROBE reads.
   localparam int NCMD = 2 * NPROBE + 1;
   localparam int CW   = $clog2(NCMD + 1);

   localparam logic [AW-1:0] ADDR_ONE   = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [AW-1:0] GUARD_ADDR = ADDR_ONE << BASE_BIT;

   typedef enum logic [3:0] {
      S_INIT      = 4'd0,
      S_ISSUE     = 4'd1,
      S_GAP       = 4'd2,
      S_WAIT      = 4'd3,
      S_DECIDE    = 4'd4,
      S_CLR_ISSUE = 4'd5,
      S_CLR_GAP   = 4'd6,
      S_CLR_WAIT  = 4'd7,
      S_IDLE      = 4'd8
   } state_t;

   state_t            state, nxt_state;
   logic [CW-1:0]     cmd_idx, nxt_cmd_idx;
   logic [AW-1:0]     nxt_mem_addr;
   logic [DW-1:0]     nxt_mem_din;
   logic              nxt_mem_we, nxt_mem_rd;
   logic [NPROBE-1:0] nxt_size_mask;
   logic              nxt_probe_done, nxt_clear_busy, nxt_clear_done;
   logic [AW-1:0]     nxt_clr_addr;
   int                cmd_k;
   int                cmd_p;

   // Probe 0 lives at address 0, probe i at bit BASE_BIT+i.
   function automatic logic [AW-1:0] probe_addr(input int p);
      if (p == 0) return '0;
      return ADDR_ONE << (BASE_BIT + p);
   endfunction

   function automatic logic [DW-1:0] probe_sig(input int p);
      return SIG_SEED + DW'(p);
   endfunction

   // Writes run highest probe first; reads follow the guard in the same order.
   // The guard slot maps to probe 0 only to keep the index in range.
   function automatic int cmd_probe(input int k);
      if (k < NPROBE)  return NPROBE - 1 - k;
      if (k == NPROBE) return 0;
      return 2 * NPROBE - k;
   endfunction

   // Next-state and next-output logic for both the probe and sweep phases.
   always_comb begin
      nxt_state      = state;
      nxt_cmd_idx    = cmd_idx;
      nxt_mem_addr   = mem_addr;
      nxt_mem_din    = mem_din;
      nxt_mem_we     = 1'b0;
      nxt_mem_rd     = 1'b0;
      nxt_size_mask  = size_mask;
      nxt_probe_done = probe_done;
      nxt_clear_busy = clear_busy;
      nxt_clear_done = clear_done;
      nxt_clr_addr   = clr_addr;
      cmd_k          = int'(cmd_idx);
      cmd_p          = cmd_probe(cmd_k);

      case (state)
         S_INIT: begin
            if (mem_ready) begin
               nxt_size_mask  = '0;
               nxt_probe_done = 1'b0;
               nxt_clear_done = 1'b0;
               nxt_clr_addr   = '0;
               nxt_cmd_idx    = '0;
               nxt_state      = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (mem_ready) begin
               if (cmd_k < NPROBE) begin
                  nxt_mem_addr = probe_addr(cmd_p);
                  nxt_mem_din  = probe_sig(cmd_p);
                  nxt_mem_we   = 1'b1;
               end else if (cmd_k == NPROBE) begin
                  nxt_mem_addr = GUARD_ADDR;
                  nxt_mem_din  = ~SIG_SEED;
                  nxt_mem_we   = 1'b1;
               end else begin
                  nxt_mem_addr = probe_addr(cmd_p);
                  nxt_mem_rd   = 1'b1;
               end
               nxt_state = S_GAP;
            end
         end
         S_GAP: begin
            // Controller may not have dropped ready yet; skip one cycle.
            nxt_state = S_WAIT;
         end
         S_WAIT: begin
            if (mem_ready) begin
               if (cmd_k > NPROBE) begin
                  for (int i = 0; i < NPROBE; i++) begin
                     if (i == cmd_p) nxt_size_mask[i] = (mem_dout == probe_sig(cmd_p));
                  end
               end
               if (cmd_k == NCMD - 1) begin
                  nxt_probe_done = 1'b1;
                  nxt_state      = S_DECIDE;
               end else begin
                  nxt_cmd_idx = cmd_idx + 1'b1;
                  nxt_state   = S_ISSUE;
               end
            end
         end
         S_DECIDE: begin
            if (clear_en) begin
               nxt_clear_busy = 1'b1;
               nxt_state      = S_CLR_ISSUE;
            end else begin
               nxt_clear_done = 1'b0;
               nxt_state      = S_IDLE;
            end
         end
         S_CLR_ISSUE: begin
            if (mem_ready) begin
               nxt_mem_addr = clr_addr;
               nxt_mem_din  = '0;
               nxt_mem_we   = 1'b1;
               nxt_state    = S_CLR_GAP;
            end
         end
         S_CLR_GAP: begin
            nxt_state = S_CLR_WAIT;
         end
         S_CLR_WAIT: begin
            if (mem_ready) begin
               if (clr_addr == CLEAR_LAST) begin
                  // Stop on the last address; clr_addr does not wrap.
                  nxt_clear_busy = 1'b0;
                  nxt_clear_done = 1'b1;
                  nxt_state      = S_IDLE;
               end else begin
                  nxt_clr_addr = clr_addr + 1'b1;
                  nxt_state    = S_CLR_ISSUE;
               end
            end
         end
         S_IDLE: begin
            nxt_state = S_IDLE;
         end
         default: begin
            nxt_state = S_INIT;
         end
      endcase

      // Restart aborts everything, including an in-flight command; the
      // command port registers keep their last values.
      if (restart) begin
         nxt_state      = S_INIT;
         nxt_cmd_idx    = '0;
         nxt_mem_addr   = mem_addr;
         nxt_mem_din    = mem_din;
         nxt_mem_we     = 1'b0;
         nxt_mem_rd     = 1'b0;
         nxt_size_mask  = '0;
         nxt_probe_done = 1'b0;
         nxt_clear_busy = 1'b0;
         nxt_clear_done = 1'b0;
         nxt_clr_addr   = '0;
      end
   end

   // State and output registers; RESET clears everything.
   always_ff @(posedge clk_sys) begin
      if (RESET) begin
         state      <= S_INIT;
         cmd_idx    <= '0;
         mem_addr   <= '0;
         mem_din    <= '0;
         mem_we     <= 1'b0;
         mem_rd     <= 1'b0;
         size_mask  <= '0;
         probe_done <= 1'b0;
         clear_busy <= 1'b0;
         clear_done <= 1'b0;
         clr_addr   <= '0;
      end else begin
         state      <= nxt_state;
         cmd_idx    <= nxt_cmd_idx;
         mem_addr   <= nxt_mem_addr;
         mem_din    <= nxt_mem_din;
         mem_we     <= nxt_mem_we;
         mem_rd     <= nxt_mem_rd;
         size_mask  <= nxt_size_mask;
         probe_done <= nxt_probe_done;
         clear_busy <= nxt_clear_busy;
         clear_done <= nxt_clear_done;
         clr_addr   <= nxt_clr_addr;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ram_probe_clear.sv
// ============================================================================
// Module      : tb_ram_probe_clear
// Description : Self-checking bench for ram_probe_clear. A behavioural SDRAM
//               model with selectable address aliasing and random ready
//               stalls answers the DUT; a command scoreboard and a mask model
//               derived from the probe/guard write list supply expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_probe_clear;

   localparam int          AW       = 27;
   localparam int          DW       = 16;
   localparam int          NPROBE   = 3;
   localparam int          BASE_BIT = 24;
   localparam logic [15:0] SEED     = 16'h0C38;
   localparam logic [26:0] CLR_LAST = 27'd15;

   logic              clk_sys = 1'b0;
   logic              RESET;
   logic              restart;
   logic              clear_en;
   logic              mem_ready;
   logic [DW-1:0]     mem_dout;
   logic [AW-1:0]     mem_addr;
   logic [DW-1:0]     mem_din;
   logic              mem_we;
   logic              mem_rd;
   logic [NPROBE-1:0] size_mask;
   logic              probe_done;
   logic              clear_busy;
   logic              clear_done;
   logic [AW-1:0]     clr_addr;

   ram_probe_clear #(
      .AW(AW), .DW(DW), .NPROBE(NPROBE), .BASE_BIT(BASE_BIT),
      .SIG_SEED(SEED), .CLEAR_LAST(CLR_LAST)
   ) dut (
      .clk_sys(clk_sys), .RESET(RESET), .restart(restart), .clear_en(clear_en),
      .mem_ready(mem_ready), .mem_dout(mem_dout), .mem_addr(mem_addr),
      .mem_din(mem_din), .mem_we(mem_we), .mem_rd(mem_rd),
      .size_mask(size_mask), .probe_done(probe_done), .clear_busy(clear_busy),
      .clear_done(clear_done), .clr_addr(clr_addr)
   );

   // Free-running system clock.
   always #5 clk_sys = ~clk_sys;

   typedef struct packed {
      logic        we;
      logic [26:0] addr;
      logic [15:0] data;
   } cmd_t;

   cmd_t        expq[$];
   logic [15:0] ram [int];
   int          alias_bits  = 27;
   int          ready_mode  = 0;   // 0: always ready, 1: random stalls, 2: never ready
   int          cyc         = 0;
   int          last_strobe = -10;
   int          n_compared  = 0;
   int          n_mismatched = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_compared++;
      if (obs !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [26:0] p_addr(input int i);
      logic [26:0] one;
      one = 27'd1;
      if (i == 0) return 27'd0;
      return one << (BASE_BIT + i);
   endfunction

   function automatic logic [15:0] p_sig(input int i);
      return SEED + 16'(i);
   endfunction

   function automatic logic [26:0] guard_addr();
      logic [26:0] one;
      one = 27'd1;
      return one << BASE_BIT;
   endfunction

   function automatic int alias_of(input logic [26:0] a, input int aw);
      return int'(a) & ((1 << aw) - 1);
   endfunction

   // Presence mask predicted by replaying the probe and guard writes into a
   // memory that keeps only the low 'aw' address bits.
   function automatic logic [2:0] model_mask(input int aw);
      logic [15:0] m [int];
      logic [2:0]  r;
      for (int i = NPROBE - 1; i >= 0; i--) m[alias_of(p_addr(i), aw)] = p_sig(i);
      m[alias_of(guard_addr(), aw)] = ~SEED;
      r = '0;
      for (int i = 0; i < NPROBE; i++) r[i] = (m[alias_of(p_addr(i), aw)] == p_sig(i));
      return r;
   endfunction

   task automatic push_probe_cmds();
      cmd_t c;
      for (int i = NPROBE - 1; i >= 0; i--) begin
         c.we = 1'b1; c.addr = p_addr(i); c.data = p_sig(i);
         expq.push_back(c);
      end
      c.we = 1'b1; c.addr = guard_addr(); c.data = ~SEED;
      expq.push_back(c);
      for (int i = NPROBE - 1; i >= 0; i--) begin
         c.we = 1'b0; c.addr = p_addr(i); c.data = 16'h0;
         expq.push_back(c);
      end
   endtask

   task automatic push_sweep_cmds();
      cmd_t c;
      for (int a = 0; a <= int'(CLR_LAST); a++) begin
         c.we = 1'b1; c.addr = 27'(a); c.data = 16'h0;
         expq.push_back(c);
      end
   endtask

   // Memory model and command scoreboard: samples strobes after each edge,
   // applies them to the aliased RAM and drives the next ready value.
   initial begin
      cmd_t e;
      logic prev_ready;
      int   k;
      mem_ready = 1'b1;
      mem_dout  = 16'h0;
      forever begin
         @(posedge clk_sys);
         #1;
         cyc++;
         prev_ready = mem_ready;
         if (mem_we || mem_rd) begin
            check_eq("strobe_exclusive", {31'b0, mem_we & mem_rd}, 32'd0);
            check_eq("strobe_ready", {31'b0, prev_ready}, 32'd1);
            check_eq("strobe_spacing", {31'b0, (cyc - last_strobe) >= 3}, 32'd1);
            last_strobe = cyc;
            if (expq.size() == 0) begin
               check_eq("cmd_unexpected", {30'b0, mem_we, mem_rd}, 32'd0);
            end else begin
               e = expq.pop_front();
               check_eq("cmd_we", {31'b0, mem_we}, {31'b0, e.we});
               check_eq("cmd_addr", {5'b0, mem_addr}, {5'b0, e.addr});
               if (e.we) check_eq("cmd_data", {16'b0, mem_din}, {16'b0, e.data});
            end
            k = alias_of(mem_addr, alias_bits);
            if (mem_we) ram[k] = mem_din;
            else        mem_dout = ram.exists(k) ? ram[k] : 16'hDEAD;
         end
         case (ready_mode)
            0:       mem_ready = 1'b1;
            2:       mem_ready = 1'b0;
            default: mem_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   task automatic check_all_zero(input string pfx);
      check_eq({pfx, "_mem_addr"},   {5'b0, mem_addr}, 32'd0);
      check_eq({pfx, "_mem_din"},    {16'b0, mem_din}, 32'd0);
      check_eq({pfx, "_strobes"},    {30'b0, mem_we, mem_rd}, 32'd0);
      check_eq({pfx, "_size_mask"},  {29'b0, size_mask}, 32'd0);
      check_eq({pfx, "_flags"},      {29'b0, probe_done, clear_busy, clear_done}, 32'd0);
      check_eq({pfx, "_clr_addr"},   {5'b0, clr_addr}, 32'd0);
   endtask

   task automatic wait_probe_done(output int c);
      c = 0;
      while (probe_done !== 1'b1 && c < 400) begin
         @(negedge clk_sys);
         c++;
      end
      check_eq("probe_done_timeout", {31'b0, probe_done}, 32'd1);
   endtask

   task automatic wait_clear_done();
      int c;
      c = 0;
      while (clear_done !== 1'b1 && c < 3000) begin
         @(negedge clk_sys);
         c++;
      end
      check_eq("clear_done_timeout", {31'b0, clear_done}, 32'd1);
   endtask

   // Called on a falling edge: pulses restart for one cycle and loads the
   // command list the rerun is expected to produce.
   task automatic pulse_restart(input bit with_sweep);
      restart = 1'b1;
      expq.delete();
      push_probe_cmds();
      if (with_sweep) push_sweep_cmds();
      @(negedge clk_sys);
      restart = 1'b0;
   endtask

   // Directed scenarios over the randomised memory model.
   initial begin
      int c;
      RESET    = 1'b1;
      restart  = 1'b0;
      clear_en = 1'b0;
      repeat (3) @(negedge clk_sys);
      check_all_zero("reset");

      // Full-size memory, no sweep: exact probe latency and idle afterwards.
      push_probe_cmds();
      RESET = 1'b0;
      wait_probe_done(c);
      check_eq("probe_latency", c, 32'd22);
      check_eq("mask_full", {29'b0, size_mask}, {29'b0, model_mask(27)});
      repeat (30) @(negedge clk_sys);
      check_eq("idle_flags", {29'b0, probe_done, clear_busy, clear_done}, 32'd4);
      check_eq("idle_queue", expq.size(), 32'd0);

      // Aliasing memories.
      alias_bits = 25;
      pulse_restart(1'b0);
      check_eq("restart_clears_done", {31'b0, probe_done}, 32'd0);
      wait_probe_done(c);
      check_eq("mask_alias25", {29'b0, size_mask}, {29'b0, model_mask(25)});
      alias_bits = 24;
      @(negedge clk_sys);
      pulse_restart(1'b0);
      wait_probe_done(c);
      check_eq("mask_alias24", {29'b0, size_mask}, {29'b0, model_mask(24)});
      check_eq("alias24_queue", expq.size(), 32'd0);

      // Sweep with random stalls.
      alias_bits = 27;
      ready_mode = 1;
      clear_en   = 1'b1;
      @(negedge clk_sys);
      pulse_restart(1'b1);
      wait_probe_done(c);
      check_eq("busy_with_probe_done", {31'b0, clear_busy}, 32'd0);
      @(negedge clk_sys);
      check_eq("busy_after_probe", {31'b0, clear_busy}, 32'd1);
      wait_clear_done();
      check_eq("sweep_clr_addr", {5'b0, clr_addr}, {5'b0, CLR_LAST});
      check_eq("sweep_busy_end", {31'b0, clear_busy}, 32'd0);
      check_eq("sweep_mask", {29'b0, size_mask}, {29'b0, model_mask(27)});
      check_eq("sweep_queue", expq.size(), 32'd0);

      // Restart in the middle of the sweep.
      @(negedge clk_sys);
      pulse_restart(1'b1);
      c = 0;
      while (clr_addr != 27'd7 && c < 3000) begin
         @(negedge clk_sys);
         c++;
      end
      check_eq("reach_clr7", {5'b0, clr_addr}, 32'd7);
      pulse_restart(1'b1);
      check_eq("midsweep_busy", {31'b0, clear_busy}, 32'd0);
      check_eq("midsweep_clr_addr", {5'b0, clr_addr}, 32'd0);
      wait_clear_done();
      check_eq("resweep_clr_addr", {5'b0, clr_addr}, {5'b0, CLR_LAST});
      check_eq("resweep_queue", expq.size(), 32'd0);

      // RESET while the controller is stalled mid-probe.
      ready_mode = 0;
      clear_en   = 1'b0;
      @(negedge clk_sys);
      pulse_restart(1'b0);
      repeat (6) @(negedge clk_sys);
      ready_mode = 2;
      repeat (3) @(negedge clk_sys);
      RESET = 1'b1;
      expq.delete();
      push_probe_cmds();
      @(negedge clk_sys);
      check_all_zero("midprobe_reset");
      RESET      = 1'b0;
      ready_mode = 0;
      wait_probe_done(c);
      check_eq("post_reset_mask", {29'b0, size_mask}, {29'b0, model_mask(27)});
      repeat (10) @(negedge clk_sys);
      check_eq("post_reset_queue", expq.size(), 32'd0);
      check_eq("post_reset_flags", {29'b0, probe_done, clear_busy, clear_done}, 32'd4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

`default_nettype wire
